// File: rtl/sd_lane_accum.sv
// rtl/sd_lane_accum.sv - multi-lane synapse weight accumulator into ping-pong Vm banks
module sd_lane_accum #(
  parameter int NNW     = 12,
  parameter int WD      = 6,
  parameter int WW      = 16,
  parameter int LAN_num = 2,
  parameter int VW      = 20,
  parameter int SAT_EN  = 1
) (
  input  logic                  clk_SD,
  input  logic                  rst_n,
  input  logic                  axon_sd_vld,
  output logic                  axon_sd_rdy,
  input  logic [NNW-1:0]        axon_sd_vm_addr,
  input  logic [WD-1:0]         axon_sd_wgt_addr,
  input  logic [LAN_num-1:0]    axon_sd_lans,
  input  logic                  sd_soma_re,
  input  logic                  sd_soma_clear,
  input  logic [NNW-1:0]        sd_soma_addr,
  output logic [VW-1:0]         sd_soma_vm,
  input  logic                  config_sd_start,
  output logic                  sd_swap_done,
  output logic                  sd_bank,
  output logic                  sd_busy,
  input  logic                  config_sd_wgt_we,
  input  logic [WD-1:0]         config_sd_wgt_addr,
  input  logic [LAN_num*WW-1:0] config_sd_wgt_wdata,
  input  logic                  config_sd_wgt_re,
  output logic [LAN_num*WW-1:0] config_sd_wgt_rdata,
  input  logic                  config_sd_vm_we,
  input  logic                  config_sd_vm_re,
  input  logic [NNW-1:0]        config_sd_vm_addr,
  input  logic [VW-1:0]         config_sd_vm_wdata,
  output logic [VW-1:0]         config_sd_vm_rdata,
  output logic                  config_sd_err
);

  localparam int SW = VW + $clog2(LAN_num) + 1;
  localparam int LW = LAN_num * WW;
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-VW+1){1'b0}}, {(VW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {ST_ACCUM, ST_DRAIN, ST_SWAP} state_t;

  logic [LW-1:0] r_wgt_mem [0:(2**WD)-1];
  logic [VW-1:0] r_vm_mem  [0:(2**(NNW+1))-1];

  state_t              r_state, w_state_nxt;
  logic                r_bank;
  logic                r_s1_vld, r_s2_vld;
  logic [NNW-1:0]      r_s1_addr, r_s2_addr;
  logic [LAN_num-1:0]  r_s1_lans, r_s2_lans;
  logic [LW-1:0]       r_s1_wgt, r_s2_wgt;
  logic [VW-1:0]       r_s2_vm;
  logic [LW-1:0]       r_wgt_rdata;
  logic [VW-1:0]       r_cfg_vm_rdata, r_soma_vm;
  logic                r_err;

  logic                w_rdy, w_swap_done, w_busy, w_accept;
  logic                w_cfg_ok, w_cfg_we, w_s1_fwd;
  logic [VW-1:0]       w_s1_vm, w_s2_res;
  logic signed [SW-1:0] w_sum;

  assign w_busy   = r_s1_vld | r_s2_vld;
  assign w_accept = axon_sd_vld & w_rdy;
  assign w_cfg_ok = ~w_busy & ~axon_sd_vld & (r_state == ST_ACCUM);
  assign w_cfg_we = config_sd_vm_we & w_cfg_ok;
  assign w_s1_fwd = r_s2_vld && (r_s2_addr == r_s1_addr);
  assign w_s1_vm  = w_s1_fwd ? w_s2_res : r_vm_mem[{r_bank, r_s1_addr}];

  assign axon_sd_rdy         = w_rdy;
  assign sd_swap_done        = w_swap_done;
  assign sd_bank             = r_bank;
  assign sd_busy             = w_busy;
  assign sd_soma_vm          = r_soma_vm;
  assign config_sd_wgt_rdata = r_wgt_rdata;
  assign config_sd_vm_rdata  = r_cfg_vm_rdata;
  assign config_sd_err       = r_err;

  // swap FSM: block new events on start, wait for the pipeline to empty, flip banks
  always_comb begin
    w_state_nxt = r_state;
    w_rdy       = 1'b0;
    w_swap_done = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        w_rdy = ~config_sd_start;
        if (config_sd_start) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (!w_busy) w_state_nxt = ST_SWAP;
      ST_SWAP: begin
        w_swap_done = 1'b1;
        w_state_nxt = ST_ACCUM;
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  // S2 arithmetic: sign-extended lane sum added to Vm, then clamp or wrap
  always_comb begin
    w_sum = {{(SW-VW){r_s2_vm[VW-1]}}, r_s2_vm};
    for (int i = 0; i < LAN_num; i++) begin
      if (r_s2_lans[i]) begin
        w_sum = w_sum + {{(SW-WW){r_s2_wgt[i*WW+WW-1]}}, r_s2_wgt[i*WW +: WW]};
      end
    end
    w_s2_res = w_sum[VW-1:0];
    if (SAT_EN != 0) begin
      if (w_sum > SAT_MAX)      w_s2_res = SAT_MAX[VW-1:0];
      else if (w_sum < SAT_MIN) w_s2_res = SAT_MIN[VW-1:0];
    end
  end

  // control state, pipeline stages and registered read ports
  always_ff @(posedge clk_SD or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_ACCUM;
      r_bank         <= 1'b0;
      r_s1_vld       <= 1'b0;
      r_s2_vld       <= 1'b0;
      r_s1_addr      <= '0;
      r_s2_addr      <= '0;
      r_s1_lans      <= '0;
      r_s2_lans      <= '0;
      r_s1_wgt       <= '0;
      r_s2_wgt       <= '0;
      r_s2_vm        <= '0;
      r_wgt_rdata    <= '0;
      r_cfg_vm_rdata <= '0;
      r_soma_vm      <= '0;
      r_err          <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_SWAP) r_bank <= ~r_bank;
      // the weight RAM has one read port: an axon accept wins over a config read
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_addr <= axon_sd_vm_addr;
        r_s1_lans <= axon_sd_lans;
        r_s1_wgt  <= r_wgt_mem[axon_sd_wgt_addr];
      end else if (config_sd_wgt_re) begin
        r_wgt_rdata <= r_wgt_mem[config_sd_wgt_addr];
      end
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_addr <= r_s1_addr;
        r_s2_lans <= r_s1_lans;
        r_s2_wgt  <= r_s1_wgt;
        r_s2_vm   <= w_s1_vm;
      end
      r_err <= (config_sd_vm_we | config_sd_vm_re) & ~w_cfg_ok;
      if (w_cfg_ok && config_sd_vm_re && !config_sd_vm_we)
        r_cfg_vm_rdata <= r_vm_mem[{r_bank, config_sd_vm_addr}];
      if (sd_soma_re)
        r_soma_vm <= r_vm_mem[{~r_bank, sd_soma_addr}];
    end
  end

  // weight RAM write port
  always_ff @(posedge clk_SD) begin
    if (config_sd_wgt_we) r_wgt_mem[config_sd_wgt_addr] <= config_sd_wgt_wdata;
  end

  // Vm RAM writes: S2 and config hit the accumulate bank, soma clear hits the drain bank
  always_ff @(posedge clk_SD) begin
    if (r_s2_vld) r_vm_mem[{r_bank, r_s2_addr}] <= w_s2_res;
    if (w_cfg_we) r_vm_mem[{r_bank, config_sd_vm_addr}] <= config_sd_vm_wdata;
    if (sd_soma_re && sd_soma_clear) r_vm_mem[{~r_bank, sd_soma_addr}] <= '0;
  end

endmodule
